// File: rtl/alu_pkg.sv
// Shared ALU types: operation encoding and sequencer state, defined once for
// both the narrow datapath and the multi-slice sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        AND = 2'b01,
        OR  = 2'b10,
        XOR = 2'b11
    } operation;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Requester-side bundle of the ALU sequencer: start/done handshake, operands,
// wide result and flags.
interface alu_seq_ctrl_if #(
    parameter int W = 8,
    parameter int N = 4
) ();
    import alu_pkg::*;

    logic             start;
    operation         op;
    logic             cin;
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [N*W-1:0]   res;
    logic             cout;
    logic             n;
    logic             z;
    logic             v;

    modport master (
        output start, op, cin, a, b,
        input  ready, busy, done, res, cout, n, z, v
    );

    modport slave (
        input  start, op, cin, a, b,
        output ready, busy, done, res, cout, n, z, v
    );

endinterface

// File: rtl/alu_param.sv
// W-bit ADD/AND/OR/XOR datapath with carry, negative, zero and overflow flags.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module alu_param
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  operation     op,
    input  logic         cin,
    output logic [W-1:0] res,
    output logic         cout,
    output logic         n,
    output logic         z,
    output logic         v
);

    logic [W:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        res  = '0;
        cout = 1'b0;
        v    = 1'b0;
        case (op)
            ADD: begin
                res  = sum[W-1:0];
                cout = sum[W];
                // Signed overflow: like-signed operands, result sign flipped.
                v    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            AND:     res = a & b;
            OR:      res = a | b;
            default: res = a ^ b;
        endcase
        n = res[W-1];
        z = (res == '0);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-precision ALU: one N*W-bit op stepped LSB-first over a W-bit alu_param.
// Latency: accept at T, results and done at T+N, next accept at T+N+2.
// Backpressure: start is honoured only while ready; it is never queued.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = N * W;

    seq_state_t     state, state_nxt;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  a_q, b_q, work_q, work_nxt, res_q;
    operation       op_q;
    logic           carry_q, zacc_q;
    logic           cout_q, n_q, z_q, v_q;

    logic [W-1:0]   a_sl, b_sl, alu_res;
    logic           alu_cout, alu_n, alu_z, alu_v;
    logic           last, is_add;

    assign is_add = (op_q == ADD);
    assign last   = (idx == IW'(N - 1));

    // Operand slice select and working-result merge for the current index.
    always_comb begin
        a_sl     = '0;
        b_sl     = '0;
        work_nxt = work_q;
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                a_sl                 = a_q[k*W +: W];
                b_sl                 = b_q[k*W +: W];
                work_nxt[k*W +: W]   = alu_res;
            end
        end
    end

    alu_param #(.W(W)) u_alu (
        .a    (a_sl),
        .b    (b_sl),
        .op   (op_q),
        .cin  (carry_q),
        .res  (alu_res),
        .cout (alu_cout),
        .n    (alu_n),
        .z    (alu_z),
        .v    (alu_v)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ADD;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            idx     <= '0;
            work_q  <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q     <= bus.a;
                    b_q     <= bus.b;
                    op_q    <= bus.op;
                    carry_q <= (bus.op == ADD) & bus.cin;
                    zacc_q  <= 1'b1;
                    idx     <= '0;
                    work_q  <= '0;
                end
                RUN: begin
                    work_q  <= work_nxt;
                    carry_q <= is_add & alu_cout;
                    zacc_q  <= zacc_q & alu_z;
                    idx     <= last ? '0 : idx + IW'(1);
                    // Published outputs change only here, all at once.
                    if (last) begin
                        res_q  <= work_nxt;
                        n_q    <= alu_n;
                        v_q    <= is_add & alu_v;
                        cout_q <= is_add & alu_cout;
                        z_q    <= zacc_q & alu_z;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == RUN) || (state == DONE);
    assign bus.done  = (state == DONE);
    assign bus.res   = res_q;
    assign bus.cout  = cout_q;
    assign bus.n     = n_q;
    assign bus.z     = z_q;
    assign bus.v     = v_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-precision ALU sequencer. Executes one N·W-bit ADD/AND/OR/XOR by stepping a single W-bit `alu_param` datapath across N slices, LSB first, with the carry chained between slices. Produces full-width N/Z/V/COUT flags. Sits between a requester using a start/done handshake and the shared narrow ALU, so wide arithmetic costs latency rather than area.

## Interface
Parameters:
- `W`, default 8: slice width; passed to the `alu_param` instance; ≥2.
- `N`, default 4: number of slices; operand width is N·W; ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  request; sampled only when `ready`=1.
- `op`  in  `operation`  ADD/AND/OR/XOR; latched on accept.
- `cin`  in  1  carry-in to slice 0; used for ADD only; latched on accept.
- `a`, `b`  in  N·W  two's-complement operands; latched on accept.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid.
- `res`  out  N·W  result.
- `cout`, `n`, `z`, `v`  out  1  carry-out, negative, zero, signed overflow of the full-width op.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: `ready`=1. If `start`=1: latch `a`, `b`, `op`, `cin`; slice index = 0; carry reg = `cin` if op==ADD, else 0; zero-accumulator = 1; go to RUN.
- RUN: the ALU receives slice[idx] of both operands, `op`, and the carry reg. On each edge:
  - Write the ALU `res` into working-result slice idx.
  - Carry reg ← ALU `cout` (ADD) or 0 (logic ops).
  - Zero-accumulator &= ALU `z`.
  - Increment idx.
- At idx==N-1, additionally:
  - Copy the working result to `res`.
  - `n` ← slice `n`, `v` ← slice `v`, `cout` ← slice `cout`. All three are forced to 0 for logic ops, except `n`, which is the result MSB for every op.
  - `z` ← accumulator & slice `z`.
  - Go to DONE.
- DONE: `done`=1 for exactly one cycle; next state is IDLE unconditionally.
- `start` is ignored in RUN and DONE and is never queued.
- Outputs `res`/flags are updated atomically only at the RUN→DONE edge. They hold their value until the next completion, including while a new op runs.
- Arithmetic: the result is modulo 2^(N·W). V follows the signed-overflow rule of the top slice only: operand MSBs equal and result MSB differs.
- N=1: exactly one RUN cycle; result equals a bare `alu_param` output.
- Reset, including mid-RUN or mid-DONE:
  - State IDLE.
  - `res`, `cout`, `n`, `z`, `v`, `done`, `busy` = 0; `ready`=1.
  - Working registers cleared.
  - No `done` is emitted for the aborted op.

## Timing
- Accept at edge T (IDLE, `start`=1).
- Slice k is written at edge T+1+k.
- Outputs update and state goes to DONE at edge T+N.
- `done` is high between edges T+N and T+N+1.
- `ready` returns high after edge T+N+1.
- Earliest next accept is edge T+N+2, so the back-to-back period is N+2 cycles.
- The ALU path is combinational within one cycle. The critical path is slice mux → W-bit add → carry reg.
- `ready`, `busy`, and `done` are decoded from registered state, with no combinational path from inputs.

## Structure
- Shared package `alu_pkg`:
  - `operation` enum (ADD=00, AND=01, OR=10, XOR=11).
  - State enum `seq_state_t` {IDLE, RUN, DONE}.
- The same package must be imported by `alu_param`, so the enum is defined once.
- One sub-module: an `alu_param #(W)` instance, u_alu. No other hierarchy.
- Slice index counter width: $clog2(N), minimum 1.

## Test plan
W=8, N=4 unless stated.
1. ADD a=0x000000FF, b=0x00000001, cin=0 → `res`=0x00000100, cout/n/z/v=0/0/0/0; `done` exactly 4 cycles after the accept edge.
2. ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, n=1, v=1, cout=0; then ADD 0xFFFFFFFF + 0x00000000, cin=1 → 0x00000000, z=1, cout=1, v=0.
3. AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000, n=1, v=0, cout=0; XOR 0xA5A5A5A5 ^ 0xA5A5A5A5 → 0, z=1; OR with cin=1 → cin ignored, cout=0.
4. `start` held high continuously for three ops → accepts exactly every 6 cycles. Each `done` is a one-cycle pulse. `res` holds the prior result during each RUN.
5. `rst` asserted on the 2nd RUN cycle → next cycle: all outputs 0, `ready`=1, no `done`. A following ADD 1+1 completes correctly with `res`=2.
6. N=1, W=3: exhaustive a, b, cin, op sweep against the reference model → identical `res`/flags to the bare `alu_param`; latency 1 RUN cycle.
